// File: rtl/module_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : module_multicycle_controller
// Brief   : Moore control FSM for a multicycle RV32I-subset datapath.
// Revision: 1.0 - initial release
// ============================================================================
module module_multicycle_controller #(
    parameter logic MEM_WAIT      = 1'b1,
    parameter logic EN_BRANCH_EXT = 1'b1,
    parameter logic EN_UPPER      = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] imm_src_o,
    output logic [3:0] alu_control_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_UPPER    = 4'd11,
        S_ILLEGAL  = 4'd15
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_ready;
    logic       w_branch_ok;
    logic       w_taken;
    logic [3:0] w_exec_alu;
    logic       w_pc_write, w_adr_src, w_mem_read, w_mem_write, w_ir_write, w_reg_write;
    logic [1:0] w_result_src, w_src_a, w_src_b;
    logic [3:0] w_alu;

    assign w_ready     = MEM_WAIT ? mem_ready_i : 1'b1;
    assign w_branch_ok = (funct3_i[2:1] != 2'b01) && (EN_BRANCH_EXT || !funct3_i[2]);

    always_comb begin
        w_taken = 1'b0;
        case (funct3_i)
            3'b000:  w_taken = zero_i;
            3'b001:  w_taken = !zero_i;
            3'b100:  w_taken = lt_i;
            3'b101:  w_taken = !lt_i;
            3'b110:  w_taken = ltu_i;
            3'b111:  w_taken = !ltu_i;
            default: w_taken = 1'b0;
        endcase
    end

    // Subtract only exists in the register form; the I form reuses bit 30 as immediate.
    always_comb begin
        w_exec_alu = 4'b0000;
        case (funct3_i)
            3'b000:  w_exec_alu = (r_state == S_EXECR && funct7b5_i) ? 4'b0001 : 4'b0000;
            3'b001:  w_exec_alu = 4'b0111;
            3'b010:  w_exec_alu = 4'b0101;
            3'b011:  w_exec_alu = 4'b0110;
            3'b100:  w_exec_alu = 4'b0100;
            3'b101:  w_exec_alu = funct7b5_i ? 4'b1001 : 4'b1000;
            3'b110:  w_exec_alu = 4'b0011;
            default: w_exec_alu = 4'b0010;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = 2'b00;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        w_alu        = 4'b0000;
        case (r_state)
            S_FETCH: begin
                w_mem_read   = 1'b1;
                w_src_b      = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = w_ready;
                w_pc_write   = w_ready;
                if (w_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_src_a = 2'b01;
                w_src_b = 2'b01;
                case (op_i)
                    c_OP_LW, c_OP_SW:     w_next = S_MEMADR;
                    c_OP_R:               w_next = S_EXECR;
                    c_OP_I:               w_next = S_EXECI;
                    c_OP_BR:              w_next = w_branch_ok ? S_BRANCH : S_ILLEGAL;
                    c_OP_JAL:             w_next = S_JAL;
                    c_OP_LUI, c_OP_AUIPC: w_next = EN_UPPER ? S_UPPER : S_ILLEGAL;
                    default:              w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                w_src_a = 2'b10;
                w_src_b = 2'b01;
                w_next  = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src  = 1'b1;
                w_mem_read = 1'b1;
                if (w_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (w_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_src_a = 2'b10;
                w_alu   = w_exec_alu;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                w_src_a = 2'b10;
                w_src_b = 2'b01;
                w_alu   = w_exec_alu;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a    = 2'b10;
                w_alu      = 4'b0001;
                w_pc_write = w_taken;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                w_src_a    = 2'b01;
                w_src_b    = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_UPPER: begin
                w_src_a = op_i[5] ? 2'b11 : 2'b01;
                w_src_b = 2'b01;
                w_next  = S_ALUWB;
            end
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:   w_next = S_ILLEGAL;
        endcase
    end

    always_comb begin
        imm_src_o = 3'b000;
        case (op_i)
            c_OP_SW:              imm_src_o = 3'b001;
            c_OP_BR:              imm_src_o = 3'b010;
            c_OP_JAL:             imm_src_o = 3'b011;
            c_OP_LUI, c_OP_AUIPC: imm_src_o = 3'b100;
            default:              imm_src_o = 3'b000;
        endcase
    end

    // Enables are gated by the reset pin so they drop the instant reset asserts.
    assign pc_write_o    = w_pc_write  & rst_n_i;
    assign ir_write_o    = w_ir_write  & rst_n_i;
    assign mem_read_o    = w_mem_read  & rst_n_i;
    assign mem_write_o   = w_mem_write & rst_n_i;
    assign reg_write_o   = w_reg_write & rst_n_i;
    assign adr_src_o     = w_adr_src;
    assign result_src_o  = w_result_src;
    assign alu_src_a_o   = w_src_a;
    assign alu_src_b_o   = w_src_b;
    assign alu_control_o = w_alu;
    assign illegal_o     = (r_state == S_ILLEGAL) & rst_n_i;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_module_multicycle_controller.sv
`default_nettype none
// Bench for module_multicycle_controller: instruction-level state-path model plus literal checks.
module tb_module_multicycle_controller;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

    logic       a_pc_write, a_adr_src, a_mem_read, a_mem_write, a_ir_write, a_reg_write, a_illegal;
    logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b;
    logic [2:0] a_imm_src;
    logic [3:0] a_alu_control, a_state;
    logic       b_pc_write, b_adr_src, b_mem_read, b_mem_write, b_ir_write, b_reg_write, b_illegal;
    logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b;
    logic [2:0] b_imm_src;
    logic [3:0] b_alu_control, b_state;

    int checks = 0;
    int failures = 0;
    int m_state = 0;
    bit m_on = 1'b0;

    int obs_st[64];
    int obs_pcw, obs_alu, obs_b, obs_b_ill, n_mw, n_st5, n_ill;

    always #5 clk = ~clk;

    module_multicycle_controller dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
        .zero_i(zero), .lt_i(lt), .ltu_i(ltu), .mem_ready_i(mem_ready),
        .pc_write_o(a_pc_write), .adr_src_o(a_adr_src), .mem_read_o(a_mem_read),
        .mem_write_o(a_mem_write), .ir_write_o(a_ir_write), .reg_write_o(a_reg_write),
        .result_src_o(a_result_src), .alu_src_a_o(a_alu_src_a), .alu_src_b_o(a_alu_src_b),
        .imm_src_o(a_imm_src), .alu_control_o(a_alu_control), .illegal_o(a_illegal),
        .state_o(a_state)
    );

    module_multicycle_controller #(.MEM_WAIT(1'b1), .EN_BRANCH_EXT(1'b0), .EN_UPPER(1'b0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
        .zero_i(zero), .lt_i(lt), .ltu_i(ltu), .mem_ready_i(mem_ready),
        .pc_write_o(b_pc_write), .adr_src_o(b_adr_src), .mem_read_o(b_mem_read),
        .mem_write_o(b_mem_write), .ir_write_o(b_ir_write), .reg_write_o(b_reg_write),
        .result_src_o(b_result_src), .alu_src_a_o(b_alu_src_a), .alu_src_b_o(b_alu_src_b),
        .imm_src_o(b_imm_src), .alu_control_o(b_alu_control), .illegal_o(b_illegal),
        .state_o(b_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Expected outputs for a given model state, written from the per-state output table.
    function automatic logic [23:0] expect_vec(int st, logic rs, logic [6:0] o, logic [2:0] f,
                                               logic f7b, logic z, logic l, logic lu, logic rdy);
        logic pcw, adr, mr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
        bit tk;
        logic [3:0] rtab[8];
        rtab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        {pcw, adr, mr, mw, irw, rw, ill} = '0;
        res = 0; sa = 0; sb = 0; alu = 0;
        tk = (f == 0) ? z : (f == 1) ? !z : (f == 4) ? l : (f == 5) ? !l :
             (f == 6) ? lu : (f == 7) ? !lu : 1'b0;
        case (st)
            0:  begin mr = 1; sb = 2; res = 2; irw = rdy; pcw = rdy; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  begin adr = 1; mr = 1; end
            4:  begin res = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; alu = rtab[f]; end
            7:  begin sa = 2; sb = 1; alu = rtab[f]; end
            8:  rw = 1;
            9:  begin sa = 2; alu = 1; pcw = tk; end
            10: begin sa = 1; sb = 2; pcw = 1; end
            11: begin sa = (o == OP_LUI) ? 2'd3 : 2'd1; sb = 1; end
            15: ill = 1;
            default: ;
        endcase
        if ((st == 6 && f == 0 && f7b) || ((st == 6 || st == 7) && f == 5 && f7b)) alu = alu + 1;
        if (!rs) {pcw, irw, mr, mw, rw, ill} = '0;
        imm = (o == OP_SW) ? 3'd1 : (o == OP_BR) ? 3'd2 : (o == OP_JAL) ? 3'd3 :
              (o == OP_LUI || o == OP_AUIPC) ? 3'd4 : 3'd0;
        return {pcw, adr, mr, mw, irw, rw, res, sa, sb, imm, alu, ill, 4'(st)};
    endfunction

    always @(negedge clk) begin
        if (m_on)
            chk($sformatf("cycle_outputs st=%0d", m_state),
                {8'd0, a_pc_write, a_adr_src, a_mem_read, a_mem_write, a_ir_write, a_reg_write,
                 a_result_src, a_alu_src_a, a_alu_src_b, a_imm_src, a_alu_control, a_illegal, a_state},
                {8'd0, expect_vec(m_state, rst_n, op, funct3, funct7b5, zero, lt, ltu, mem_ready)});
    end

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f,
                             input logic f7b, input logic z, input logic l, input logic lu,
                             input int fw, input int mw, input int nill, input int abort_k);
        int  st_q[$];
        bit  rd_q[$];
        for (int i = 0; i < fw; i++) begin st_q.push_back(0); rd_q.push_back(1'b0); end
        st_q.push_back(0); rd_q.push_back(1'b1);
        st_q.push_back(1); rd_q.push_back(1'b0);
        if (o == OP_LW || o == OP_SW) begin
            int ms;
            ms = (o == OP_LW) ? 3 : 5;
            st_q.push_back(2); rd_q.push_back(1'b0);
            for (int i = 0; i < mw; i++) begin st_q.push_back(ms); rd_q.push_back(1'b0); end
            st_q.push_back(ms); rd_q.push_back(1'b1);
            if (o == OP_LW) begin st_q.push_back(4); rd_q.push_back(1'b0); end
        end else if (o == OP_R) begin
            st_q.push_back(6); st_q.push_back(8); rd_q.push_back(1'b0); rd_q.push_back(1'b0);
        end else if (o == OP_I) begin
            st_q.push_back(7); st_q.push_back(8); rd_q.push_back(1'b0); rd_q.push_back(1'b0);
        end else if (o == OP_BR && f[2:1] != 2'b01) begin
            st_q.push_back(9); rd_q.push_back(1'b0);
        end else if (o == OP_JAL) begin
            st_q.push_back(10); st_q.push_back(8); rd_q.push_back(1'b0); rd_q.push_back(1'b0);
        end else if (o == OP_LUI || o == OP_AUIPC) begin
            st_q.push_back(11); st_q.push_back(8); rd_q.push_back(1'b0); rd_q.push_back(1'b0);
        end else begin
            for (int i = 0; i < nill; i++) begin st_q.push_back(15); rd_q.push_back(1'b0); end
        end
        n_mw = 0; n_st5 = 0; n_ill = 0; obs_pcw = -1; obs_alu = -1;
        foreach (st_q[k]) begin
            @(posedge clk);
            #1;
            op = o; funct3 = f; funct7b5 = f7b; zero = z; lt = l; ltu = lu;
            mem_ready = rd_q[k]; m_state = st_q[k];
            if (k == abort_k) begin
                #1 rst_n = 1'b0; m_state = 0;
                #1;
                chk({name, " abort_state"}, 32'(a_state), 32'd0);
                chk({name, " abort_enables"},
                    {27'd0, a_pc_write, a_ir_write, a_mem_read, a_mem_write, a_reg_write}, 32'd0);
                @(posedge clk);
                #1 rst_n = 1'b1; mem_ready = 1'b0;
                return;
            end
            #2;
            obs_st[k] = int'(a_state);
            if (a_mem_write) n_mw++;
            if (a_state == 4'd5) n_st5++;
            if (a_state == 4'd15 && a_illegal) n_ill++;
            if (st_q[k] == 9) obs_pcw = int'(a_pc_write);
            if (st_q[k] == 6 || st_q[k] == 7) obs_alu = int'(a_alu_control);
            obs_b = int'(b_state); obs_b_ill = int'(b_illegal);
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1 rst_n = 1'b0; mem_ready = 1'b0; m_state = 0;
        #1;
        chk({name, " state"}, 32'(a_state), 32'd0);
        chk({name, " illegal"}, 32'(a_illegal), 32'd0);
        chk({name, " enables"},
            {27'd0, a_pc_write, a_ir_write, a_mem_read, a_mem_write, a_reg_write}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        m_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr("lw", OP_LW, 3'd2, 0, 0, 0, 0, 0, 0, 0, -1);
        chk("lw path", {obs_st[0][7:0], obs_st[1][7:0], obs_st[2][7:0], obs_st[3][7:0]}, 32'h00010203);
        chk("lw path wb", 32'(obs_st[4]), 32'd4);
        run_instr("lw_wait", OP_LW, 3'd2, 0, 0, 0, 0, 2, 2, 0, -1);

        run_instr("sw_wait", OP_SW, 3'd2, 0, 0, 0, 0, 0, 2, 0, -1);
        chk("sw mem_write cycles", 32'(n_mw), 32'd3);
        chk("sw state5 cycles", 32'(n_st5), 32'd3);

        run_instr("sub", OP_R, 3'd0, 1, 0, 0, 0, 0, 0, 0, -1);
        chk("sub alu", 32'(obs_alu), 32'd1);
        run_instr("addi_f7", OP_I, 3'd0, 1, 0, 0, 0, 0, 0, 0, -1);
        chk("addi alu", 32'(obs_alu), 32'd0);
        run_instr("srai", OP_I, 3'd5, 1, 0, 0, 0, 0, 0, 0, -1);
        chk("srai alu", 32'(obs_alu), 32'd9);
        for (int f = 0; f < 8; f++)
            run_instr("r_ops", OP_R, 3'(f), 0, 0, 0, 0, 0, 0, 0, -1);
        chk("and alu", 32'(obs_alu), 32'd2);
        for (int f = 0; f < 8; f++)
            run_instr("i_ops", OP_I, 3'(f), 0, 0, 0, 0, 1, 0, 0, -1);

        run_instr("beq_t", OP_BR, 3'd0, 0, 1, 0, 0, 0, 0, 0, -1);
        chk("beq taken", 32'(obs_pcw), 32'd1);
        chk("b beq legal", 32'(obs_b), 32'd9);
        run_instr("bne_nt", OP_BR, 3'd1, 0, 1, 0, 0, 0, 0, 0, -1);
        chk("bne not taken", 32'(obs_pcw), 32'd0);
        run_instr("bge_t", OP_BR, 3'd5, 0, 0, 0, 1, 0, 0, 0, -1);
        run_instr("bltu_t", OP_BR, 3'd6, 0, 0, 1, 1, 0, 0, 0, -1);
        chk("bltu taken", 32'(obs_pcw), 32'd1);
        chk("b bltu state", 32'(obs_b), 32'd15);
        chk("b bltu illegal", 32'(obs_b_ill), 32'd1);
        run_instr("bltu_nt", OP_BR, 3'd6, 0, 1, 1, 0, 0, 0, 0, -1);
        chk("bltu not taken", 32'(obs_pcw), 32'd0);
        run_instr("bgeu_t", OP_BR, 3'd7, 0, 0, 0, 0, 0, 0, 0, -1);
        run_instr("br_f3_010", OP_BR, 3'd2, 0, 0, 0, 0, 0, 0, 3, -1);
        chk("br 010 illegal", 32'(n_ill), 32'd3);
        do_reset("rst_after_br");

        run_instr("jal", OP_JAL, 3'd0, 0, 0, 0, 0, 0, 0, 0, -1);
        run_instr("lui", OP_LUI, 3'd0, 0, 0, 0, 0, 0, 0, 0, -1);
        chk("b lui illegal", 32'(obs_b), 32'd15);
        run_instr("auipc", OP_AUIPC, 3'd0, 0, 0, 0, 0, 1, 0, 0, -1);

        run_instr("bad_op", OP_BAD, 3'd0, 0, 0, 0, 0, 0, 0, 10, -1);
        chk("illegal sticky cycles", 32'(n_ill), 32'd10);
        do_reset("rst_after_illegal");

        run_instr("lw_abort", OP_LW, 3'd2, 0, 0, 0, 0, 0, 3, 0, 4);
        run_instr("lw_after", OP_LW, 3'd2, 0, 0, 0, 0, 0, 0, 0, -1);
        chk("lw after abort", 32'(obs_st[4]), 32'd4);

        @(posedge clk);
        #1 m_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/module_multicycle_controller.md
MODULE_MULTICYCLE_CONTROLLER -- requirements
Module: module_multicycle_controller

Interface
REQ-001 SHALL have parameters: MEM_WAIT, 1, 1 = FETCH/MEMREAD/MEMWRITE stall until mem_ready_i, 0 = mem_ready_i ignored (treated high).
REQ-002 SHALL have parameters: EN_BRANCH_EXT, 1, 1 = blt/bge/bltu/bgeu legal, 0 = beq/bne only.
REQ-003 SHALL have parameters: EN_UPPER, 1, 1 = lui/auipc legal, 0 = illegal.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_n_i in 1 asynchronous active-low reset.
REQ-005 SHALL have inputs: op_i 7 opcode; funct3_i 3; funct7b5_i 1; zero_i 1 ALU zero; lt_i 1 signed rs1<rs2; ltu_i 1 unsigned rs1<rs2; mem_ready_i 1 memory access complete.
REQ-006 SHALL have outputs: pc_write_o 1; adr_src_o 1 (0 PC, 1 ALUOut); mem_read_o 1; mem_write_o 1; ir_write_o 1; reg_write_o 1; result_src_o 2 (00 ALUOut, 01 mem data, 10 ALU result); alu_src_a_o 2 (00 PC, 01 oldPC, 10 rs1, 11 zero); alu_src_b_o 2 (00 rs2, 01 imm, 10 const 4); imm_src_o 3 (000 I, 001 S, 010 B, 011 J, 100 U); alu_control_o 4; illegal_o 1 sticky; state_o 4 debug.

Function
REQ-007 SHALL implement Moore FSM, state_o encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, UPPER 11, ILLEGAL 15.
REQ-008 SHALL in FETCH drive adr_src 0, mem_read 1, src_a 00, src_b 10, ALU add, result_src 10; ir_write and pc_write = mem_ready_i; advance to DECODE only on edge with mem_ready_i high.
REQ-009 SHALL in DECODE drive src_a 01, src_b 01, add; next: lw(0000011)/sw(0100011)->MEMADR, R(0110011)->EXECR, I-ALU(0010011)->EXECI, branch(1100011)->BRANCH, jal(1101111)->JAL, lui(0110111)/auipc(0010111)->UPPER, else ILLEGAL.
REQ-010 SHALL in MEMADR drive src_a 10, src_b 01, add; next MEMREAD if op_i[5]=0, else MEMWRITE.
REQ-011 SHALL in MEMREAD drive adr_src 1, mem_read 1, result_src 00; advance to MEMWB on mem_ready_i high.
REQ-012 SHALL in MEMWRITE drive adr_src 1, result_src 00, mem_write 1 held until mem_ready_i high, then FETCH.
REQ-013 SHALL in MEMWB drive result_src 01, reg_write 1; in ALUWB drive result_src 00, reg_write 1; both -> FETCH.
REQ-014 SHALL in EXECR drive src_a 10, src_b 00; EXECI src_a 10, src_b 01; both use decoded ALU op, -> ALUWB.
REQ-015 SHALL decode alu_control for EXECR/EXECI by funct3: 000 add (0000), or sub (0001) only if R and funct7b5; 001 sll 0111; 010 slt 0101; 011 sltu 0110; 100 xor 0100; 101 srl 1000 / sra 1001 if funct7b5; 110 or 0011; 111 and 0010. All other states: add 0000, except BRANCH sub 0001.
REQ-016 SHALL in BRANCH drive src_a 10, src_b 00, sub, result_src 00; pc_write = taken: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; -> FETCH.
REQ-017 SHALL in JAL drive src_a 01, src_b 10, add, result_src 00, pc_write 1; -> ALUWB.
REQ-018 SHALL in UPPER drive src_a 11 for lui / 01 for auipc, src_b 01, add; -> ALUWB.
REQ-019 SHALL treat as illegal in DECODE: undecoded opcode, branch funct3 010/011, funct3 1xx when EN_BRANCH_EXT=0, lui/auipc when EN_UPPER=0.
REQ-020 SHALL in ILLEGAL assert illegal_o, deassert all write/read enables, remain until reset.
REQ-021 SHALL drive imm_src combinationally from op_i in every state: sw S, branch B, jal J, lui/auipc U, else I.
REQ-022 SHALL yield CPI with no wait states: lw 5, sw 4, R/I 4, branch 3, jal 4, lui/auipc 4; each low mem_ready_i cycle adds one.
REQ-023 SHALL deassert unlisted enables (0) in each state.

Reset
REQ-024 SHALL on rst_n_i low asynchronously enter FETCH, clear illegal_o, force pc_write, ir_write, mem_read, mem_write, reg_write to 0 while low, including mid-instruction or mid-wait.
REQ-025 SHALL resume FETCH behaviour on first rising edge after rst_n_i high.

Verification
REQ-026 lw (op 0000011), mem_ready_i=1 -> states 0,1,2,3,4,0; reg_write only in state 4 with result_src 01.
REQ-027 sw, mem_ready_i low 2 cycles in MEMWRITE -> mem_write_o high 3 cycles, state 5 held, then 0.
REQ-028 bltu (funct3 110), ltu_i=1 -> BRANCH pc_write_o=1; ltu_i=0 -> 0; EN_BRANCH_EXT=0 -> state 15, illegal_o=1.
REQ-029 R sub (funct3 000, funct7b5 1) -> EXECR alu_control 0001; I addi funct7b5 1 -> 0000; srai -> 1001.
REQ-030 op 1111111 -> ILLEGAL sticky for 10 cycles, all enables 0; rst_n_i low -> FETCH, illegal_o 0.
REQ-031 rst_n_i pulsed low asynchronously during MEMREAD wait -> state 0, enables 0 immediately.
